// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART receiver state encoding and oversampling constants.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  // Clock cycles per oversampling tick, truncated; never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO, power-of-two depth.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_count = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == c_full_count);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver, 16x oversampled, feeding a FWFT byte FIFO.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 48_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       uart_rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int DIV    = calc_div(CLK_HZ, BAUD);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(DIV - 1);
  localparam logic [3:0]        c_os_last   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]        c_os_mid    = 4'(MID_TICK);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_rx_prev;
  logic [TICK_W-1:0] r_tick_cnt;
  uart_state_e       r_state;
  logic [3:0]        r_os_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_push;
  logic [7:0]        r_push_data;

  logic w_start_edge;
  logic w_tick;
  logic w_stop_sample;
  logic w_frame_bad;
  logic w_pop;
  logic w_full;
  logic w_empty;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= uart_rx_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_start_edge = r_rx_prev && !r_sync2;
  assign w_tick       = (r_tick_cnt == c_tick_last);

  // Restarting on the start edge aligns every later tick to the frame.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if ((r_state == IDLE && w_start_edge) || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_os_cnt    <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_state  <= START;
            r_os_cnt <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_os_cnt == c_os_mid) begin
              r_os_cnt  <= '0;
              r_bit_cnt <= '0;
              r_state   <= r_sync2 ? IDLE : DATA;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_os_cnt == c_os_last) begin
              r_os_cnt <= '0;
              r_shift  <= {r_sync2, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) r_state <= STOP;
              else                   r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_os_cnt == c_os_last) begin
              r_os_cnt    <= '0;
              r_state     <= IDLE;
              r_push      <= r_sync2;
              r_push_data <= r_shift;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_stop_sample = (r_state == STOP) && w_tick && (r_os_cnt == c_os_last);
  assign w_frame_bad   = w_stop_sample && !r_sync2;
  assign w_pop         = rx_valid && rx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_48mhz),
    .rst_n   (reset_n),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rx_valid = !w_empty;

  // Setting a flag takes priority over a simultaneous clear.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_frame_bad)  frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (r_push && w_full && !w_pop) overrun <= 1'b1;
      else if (err_clr)               overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Scoreboard bench for uart_rx_fifo with a queue-based byte model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 48_000_000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 4;
  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int BIT    = DIV * 16;
  localparam int HALF   = BIT / 2;

  logic       clk_48mhz  = 1'b0;
  logic       reset_n    = 1'b0;
  logic       uart_rx_in = 1'b1;
  logic       rx_ready   = 1'b0;
  logic       err_clr    = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int         n_checks   = 0;
  int         n_errors   = 0;
  int         ready_mode = 0;
  logic       exp_ovr    = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .reset_n    (reset_n),
    .uart_rx_in (uart_rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  // Consumer: 0 = stalled, 1 = always ready, otherwise random.
  always @(posedge clk_48mhz) begin
    #1;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard monitor: every accepted byte must be the oldest expected one.
  always @(negedge clk_48mhz) begin
    logic [7:0] e;
    if (reset_n && rx_valid && rx_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pop_unexpected: got %02h, expected no byte", rx_data);
      end else begin
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          n_errors++;
          $display("FAIL pop_data: got %02h, expected %02h", rx_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  // Reference rule: a good frame is buffered unless a stalled FIFO is full.
  task automatic model_push(input logic [7:0] b);
    if (ready_mode == 0 && exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else                                          exp_q.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int lat);
    uart_rx_in = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      wait_cyc(BIT);
    end
    uart_rx_in = stop_bit;
    if (stop_bit) model_push(b);
    lat = -1;
    wait_cyc(HALF);
    for (int k = 0; k < BIT - HALF; k++) begin
      @(negedge clk_48mhz);
      if (rx_valid && lat < 0) lat = k;
      wait_cyc(1);
    end
    uart_rx_in = 1'b1;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      wait_cyc(1);
    end
    chk("drain_complete", exp_q.size(), 0);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
  endtask

  initial begin
    #(120_000 * 10);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] b;
    logic       bad;
    int         gap;

    wait_cyc(3);
    @(negedge clk_48mhz);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    wait_cyc(1);
    reset_n = 1'b1;
    wait_cyc(20);

    // Single frame, consumer stalled.
    ready_mode = 0;
    chk("a5_valid_before", rx_valid, 0);
    send_frame(8'hA5, 1'b1, lat);
    chk("a5_latency_le12", (lat >= 0 && lat <= 12), 1);
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_rx_valid", rx_valid, 1);
    chk("a5_frame_err", frame_err, 0);
    ready_mode = 1;
    wait_drain(50);
    ready_mode = 0;

    // Short low glitch must be rejected, then a real frame still works.
    uart_rx_in = 1'b0;
    wait_cyc(100);
    uart_rx_in = 1'b1;
    wait_cyc(BIT);
    chk("glitch_rx_valid", rx_valid, 0);
    chk("glitch_frame_err", frame_err, 0);
    b = 8'($urandom());
    send_frame(b, 1'b1, lat);
    chk("post_glitch_rx_data", rx_data, b);
    ready_mode = 1;
    wait_drain(50);
    ready_mode = 0;

    // Framing error and its clear.
    send_frame(8'h3C, 1'b0, lat);
    chk("ferr_set", frame_err, 1);
    chk("ferr_fifo_empty", rx_valid, 0);
    pulse_err_clr();
    @(negedge clk_48mhz);
    chk("ferr_cleared", frame_err, 0);
    wait_cyc(1);

    // Overflow: five frames into a four-deep stalled FIFO.
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, lat);
    chk("ovr_set", overrun, exp_ovr);
    chk("ovr_head", rx_data, 8'h01);
    ready_mode = 1;
    wait_drain(100);
    ready_mode = 0;
    wait_cyc(2);
    chk("ovr_drained_valid", rx_valid, 0);

    // Reset in the middle of bit 3 with a byte already buffered.
    send_frame(8'($urandom()), 1'b1, lat);
    b = 8'($urandom());
    uart_rx_in = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 3; i++) begin
      uart_rx_in = b[i];
      wait_cyc(BIT);
    end
    uart_rx_in = b[3];
    wait_cyc(HALF);
    reset_n    = 1'b0;
    uart_rx_in = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    wait_cyc(3);
    @(negedge clk_48mhz);
    chk("midreset_rx_valid", rx_valid, 0);
    chk("midreset_rx_data", rx_data, 8'h00);
    chk("midreset_frame_err", frame_err, 0);
    chk("midreset_overrun", overrun, 0);
    wait_cyc(1);
    reset_n = 1'b1;
    wait_cyc(BIT);
    chk("postreset_no_resume", rx_valid, 0);
    send_frame(8'h5A, 1'b1, lat);
    chk("postreset_rx_data", rx_data, 8'h5A);
    chk("postreset_rx_valid", rx_valid, 1);
    ready_mode = 1;
    wait_drain(50);

    // Back-to-back frames with a ready consumer.
    send_frame(8'h00, 1'b1, lat);
    send_frame(8'hFF, 1'b1, lat);
    wait_drain(50);
    chk("b2b_frame_err", frame_err, 0);
    chk("b2b_overrun", overrun, 0);

    // Random traffic with a random consumer and occasional bad stop bits.
    ready_mode = 2;
    for (int n = 0; n < 4; n++) begin
      b   = 8'($urandom());
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, !bad, lat);
      if (bad) begin
        chk("rand_ferr_set", frame_err, 1);
        pulse_err_clr();
        @(negedge clk_48mhz);
        chk("rand_ferr_clear", frame_err, 0);
        wait_cyc(1);
      end
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 300));
      if (gap > 0) wait_cyc(gap);
    end
    wait_drain(100);
    chk("rand_overrun", overrun, 0);
    ready_mode = 0;
    wait_cyc(5);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
